prog_fetch_seq: RTL and testbench
=================================

Name: prog_fetch_seq

Overview:
- Parametrised successor to the fixed-case instruction ROM: a writable multi-program instruction store plus a fetch sequencer.
- Software (or the board loader) writes programs into per-program slots. `start` selects a program and the block streams its instructions to the execute stage over a valid/ready handshake, one instruction per cycle at full throughput.
- A run terminates on the OUT opcode, an unwritten slot, or end of program depth.

Parameters:
- INSTR_W, 8, instruction width; opcode is the top 4 bits.
- NUM_PROGS, 4, number of program slots.
- PROG_DEPTH, 16, instructions per program.
- OPC_OUT, 4'b1011, opcode that ends a run.
- Derived: PW = clog2(NUM_PROGS), AW = clog2(PROG_DEPTH); each minimum 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe for program store.
- wr_prog  in  PW  program slot to write.
- wr_addr  in  AW  instruction index to write.
- wr_data  in  INSTR_W  instruction word.
- start  in  1  begin run; honoured only in IDLE.
- prog_sel  in  PW  program to run; sampled with start.
- instr  out  INSTR_W  current instruction.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  execute stage accepts instr.
- pc  out  AW  index of the instruction on instr.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on run termination.
- error  out  1  one-cycle pulse with done on abnormal termination.

Behaviour:
- Storage: NUM_PROGS*PROG_DEPTH words, each with a written bit.
- Synchronous reset:
  - clears all written bits, so the store reads as empty.
  - returns the FSM to IDLE.
  - drives instr=0, instr_valid=0, pc=0, busy=0, done=0, error=0.
  - takes effect mid-run too: no done or error pulse is emitted.
- Writes:
  - Accepted only when not busy: the word is stored and its written bit set.
  - wr_en while busy is ignored; the store is unchanged.
  - wr_en and start in the same IDLE cycle: the write commits first, and the fetch of index 0 on the next edge sees the new word.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 latches prog_sel into p and sets pc=0.
  - If slot (p,0) is written: next cycle is RUN with instr=mem[p][0], instr_valid=1, busy=1. Latency is 1 cycle from start to the first valid.
  - If slot (p,0) is unwritten: stay IDLE; pulse done=1 and error=1 next cycle; instr_valid stays 0.
- RUN, when instr_valid=1 and instr_ready=0:
  - instr and pc are held stable.
  - start is ignored.
- RUN, on handshake (instr_valid and instr_ready):
  - instr[INSTR_W-1 -: 4]==OPC_OUT: go to IDLE next cycle with instr_valid=0, busy=0, done=1, error=0.
  - Otherwise, pc==PROG_DEPTH-1: go to IDLE with done=1, error=1. pc does not wrap into another program.
  - Otherwise, slot (p,pc+1) unwritten: go to IDLE with done=1, error=1, instr_valid=0.
  - Otherwise: pc<=pc+1, instr<=mem[p][pc+1], instr_valid stays 1. This sustains back-to-back, one instruction per cycle.
- instr keeps its last value after a run ends. It is only meaningful while instr_valid=1.
- done and error are strictly single-cycle pulses and never assert while busy is low except in the termination cycle.
- No combinational path from any input to instr_valid, instr, or pc; those are registered. busy is decoded from the state register.

Test Plan:
- Reset, then write prog 0 = {0x90,0xA4,0x21,0x80,0xB0}; start prog_sel=0 with ready=1 -> instr 0x90,0xA4,0x21,0x80,0xB0 on 5 consecutive cycles with pc 0..4; done=1, error=0 the cycle after 0xB0 is accepted; busy then 0.
- Same program, ready toggling 1,0,0,1,... -> each instr/pc held while ready=0; the sequence is unchanged with no skips or duplicates; done after 0xB0.
- Write prog 2 = {0x90,0x10} only; start prog_sel=2 -> 0x90, 0x10 delivered, then done=1 and error=1 because slot (2,2) is unwritten.
- Fill prog 3 with 16 words of 0x00 and no OUT -> 16 instructions with pc 0..15, then done=1 and error=1; pc never reads another program.
- Mid-run: assert wr_en to (0,1)=0xFF, then rst at pc=2 -> the write is ignored; after reset instr_valid=0, busy=0, no done pulse; start prog 0 -> immediate done=1, error=1 because the store was cleared.
- start with prog_sel=1 on a fresh store -> done=1 and error=1 one cycle later; instr_valid never asserts.

Source files
------------

// File: rtl/prog_fetch_seq.sv
// Multi-program instruction store with a valid/ready fetch sequencer.
// start selects a slot; words stream out until OUT, an unwritten word, or the end of the slot.
module prog_fetch_seq #(
  parameter int INSTR_W = 8,
  parameter int NUM_PROGS = 4,
  parameter int PROG_DEPTH = 16,
  parameter logic [3:0] OPC_OUT = 4'b1011,
  localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PW-1:0]      wr_prog,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               start,
  input  logic [PW-1:0]      prog_sel,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int N = NUM_PROGS * PROG_DEPTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(PROG_DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [INSTR_W-1:0] mem [N];
  logic [N-1:0]       written;

  logic [PW-1:0]      p, p_n;
  logic [AW-1:0]      pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n, done_n, error_n;

  logic               wr_acc;
  logic [IW-1:0]      wr_idx;
  logic [PW-1:0]      f_prog;
  logic [AW-1:0]      f_addr;
  logic [IW-1:0]      f_idx;
  logic               f_hit, f_ok;
  logic [INSTR_W-1:0] f_word;

  function automatic logic [IW-1:0] idx_of(
    input logic [PW-1:0] pp,
    input logic [AW-1:0] aa
  );
    return IW'(pp) * IW'(PROG_DEPTH) + IW'(aa);
  endfunction

  assign busy   = (state == RUN);
  assign wr_acc = wr_en && (state == IDLE);
  assign wr_idx = idx_of(wr_prog, wr_addr);

  assign f_prog = (state == IDLE) ? prog_sel : p;
  assign f_addr = (state == IDLE) ? '0 : pc + AW'(1);
  assign f_idx  = idx_of(f_prog, f_addr);

  // A write landing in the same cycle as start is forwarded to the first fetch.
  assign f_hit  = wr_acc && (wr_prog == prog_sel) && (wr_addr == '0);
  assign f_ok   = f_hit || written[f_idx];
  assign f_word = f_hit ? wr_data : mem[f_idx];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      written     <= '0;
      p           <= '0;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      done        <= done_n;
      error       <= error_n;
      if (wr_acc) written[wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    p_n     = p;
    pc_n    = pc;
    instr_n = instr;
    valid_n = instr_valid;
    done_n  = 1'b0;
    error_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          p_n  = prog_sel;
          pc_n = '0;
          if (f_ok) begin
            state_n = RUN;
            instr_n = f_word;
            valid_n = 1'b1;
          end else begin
            done_n  = 1'b1;
            error_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (instr_valid && instr_ready) begin
          if (instr[INSTR_W-1 -: 4] == OPC_OUT) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else if (pc == LAST || !f_ok) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
            error_n = 1'b1;
          end else begin
            pc_n    = pc + AW'(1);
            instr_n = f_word;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Directed bench for prog_fetch_seq: checks are immediate assertions
// taken 1 ns after each rising edge; inputs change at the same point.
module tb_prog_fetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_prog = '0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [1:0] prog_sel = '0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] pc;
  logic       busy, done, error;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] p0 [5] = '{8'h90, 8'hA4, 8'h21, 8'h80, 8'hB0};

  prog_fetch_seq dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_prog(wr_prog),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_sel(prog_sel),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] pp, input logic [3:0] aa,
                    input logic [7:0] dd);
    wr_en = 1'b1;
    wr_prog = pp;
    wr_addr = aa;
    wr_data = dd;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle_chk(input string tag, input logic d, input logic e);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
  endtask

  initial begin
    int idx;
    #1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_chk("rst", 1'b0, 1'b0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);

    // full-throughput run of program 0
    for (int i = 0; i < 5; i++) wr(2'd0, 4'(i), p0[i]);
    start = 1'b1;
    prog_sel = 2'd0;
    instr_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_instr", 32'(instr), 32'(p0[i]));
      chk("t1_pc", 32'(pc), 32'(i));
      chk("t1_done", 32'(done), 32'd0);
      tick();
    end
    idle_chk("t1_end", 1'b1, 1'b0);
    tick();
    idle_chk("t1_post", 1'b0, 1'b0);

    // same program with back-pressure 1,0,0,1,0,0,...
    start = 1'b1;
    prog_sel = 2'd0;
    instr_ready = 1'b0;
    tick();
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      instr_ready = (c % 3 == 0);
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_instr", 32'(instr), 32'(p0[idx]));
      chk("t2_pc", 32'(pc), 32'(idx));
      tick();
      if (c % 3 == 0) idx++;
    end
    chk("t2_count", 32'(idx), 32'd5);
    instr_ready = 1'b1;
    idle_chk("t2_end", 1'b1, 1'b0);
    tick();

    // program 2 runs into an unwritten slot
    wr(2'd2, 4'd0, 8'h90);
    wr(2'd2, 4'd1, 8'h10);
    start = 1'b1;
    prog_sel = 2'd2;
    tick();
    start = 1'b0;
    chk("t3_i0", 32'(instr), 32'h90);
    chk("t3_pc0", 32'(pc), 32'd0);
    tick();
    chk("t3_i1", 32'(instr), 32'h10);
    chk("t3_pc1", 32'(pc), 32'd1);
    chk("t3_v1", 32'(instr_valid), 32'd1);
    tick();
    idle_chk("t3_end", 1'b1, 1'b1);
    tick();

    // program 3 fills the whole slot without OUT
    for (int i = 0; i < 16; i++) wr(2'd3, 4'(i), 8'h00);
    start = 1'b1;
    prog_sel = 2'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t4_valid", 32'(instr_valid), 32'd1);
      chk("t4_instr", 32'(instr), 32'h00);
      chk("t4_pc", 32'(pc), 32'(i));
      tick();
    end
    idle_chk("t4_end", 1'b1, 1'b1);
    chk("t4_pc_end", 32'(pc), 32'd15);
    tick();

    // writes while busy are dropped; reset mid-run clears the store
    start = 1'b1;
    prog_sel = 2'd0;
    tick();
    start = 1'b0;
    chk("t5_pc0", 32'(pc), 32'd0);
    wr(2'd0, 4'd2, 8'hFF);
    chk("t5_pc1", 32'(pc), 32'd1);
    chk("t5_i1", 32'(instr), 32'hA4);
    wr(2'd0, 4'd1, 8'hFF);
    chk("t5_pc2", 32'(pc), 32'd2);
    chk("t5_i2", 32'(instr), 32'h21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_chk("t5_rst", 1'b0, 1'b0);
    tick();
    idle_chk("t5_idle", 1'b0, 1'b0);
    start = 1'b1;
    prog_sel = 2'd0;
    tick();
    start = 1'b0;
    idle_chk("t5_empty", 1'b1, 1'b1);
    tick();
    idle_chk("t5_post", 1'b0, 1'b0);

    // fresh store: start on program 1
    start = 1'b1;
    prog_sel = 2'd1;
    tick();
    start = 1'b0;
    idle_chk("t6_empty", 1'b1, 1'b1);
    tick();
    idle_chk("t6_post", 1'b0, 1'b0);

    // write and start together: first fetch sees the new word
    wr_en = 1'b1;
    wr_prog = 2'd1;
    wr_addr = 4'd0;
    wr_data = 8'h5A;
    start = 1'b1;
    prog_sel = 2'd1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("t7_valid", 32'(instr_valid), 32'd1);
    chk("t7_instr", 32'(instr), 32'h5A);
    chk("t7_busy", 32'(busy), 32'd1);
    tick();
    idle_chk("t7_end", 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
